// File: rtl/ahb_wrr_burst_arbiter_pkg.sv
// Shared types and helpers for the AHB weighted round-robin burst arbiter.
// Burst encodings follow the standard AMBA HBURST values.
package ahb_wrr_burst_arbiter_pkg;

  localparam int HBURST_W = 3;
  localparam int BEAT_W   = 5;

  typedef enum logic [HBURST_W-1:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Zero marks an open-ended INCR burst.
  function automatic logic [BEAT_W-1:0] burst_beats(
    input hburst_t b
  );
    logic [BEAT_W-1:0] n;
    case (b)
      HB_SINGLE:            n = 5'd1;
      HB_WRAP4, HB_INCR4:   n = 5'd4;
      HB_WRAP8, HB_INCR8:   n = 5'd8;
      HB_WRAP16, HB_INCR16: n = 5'd16;
      default:              n = 5'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating find-first: first set bit of eligible at or after rr_ptr,
// wrapping around, returned one-hot.
module ahb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         winner,
  output logic                 valid
);

  localparam int PW = $clog2(N);
  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [PW:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= N_W) begin
        idx = idx - N_W;
      end
      if (!valid && eligible[idx[PW-1:0]]) begin
        winner[idx[PW-1:0]] = 1'b1;
        valid               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_wrr_burst_arbiter.sv
// Per-slave AHB arbiter: weighted round robin with burst hold
// and starvation override; drives hmaster/hsel for the slave mux.
module ahb_wrr_burst_arbiter
  import ahb_wrr_burst_arbiter_pkg::*;
#(
  parameter int MASTER_NUM     = 4,
  parameter int WEIGHT_BIT     = 3,
  parameter int STARVE_LIMIT   = 32,
  parameter int MAX_INCR_BEATS = 16
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [MASTER_NUM-1:0]          hreq,
  input  logic [MASTER_NUM*HBURST_W-1:0] hburst,
  input  logic                           hready,
  input  logic [MASTER_NUM*WEIGHT_BIT-1:0] weight_cfg,
  output logic [MASTER_NUM-1:0]          hgrant,
  output logic [$clog2(MASTER_NUM)-1:0]  hmaster,
  output logic                           hsel,
  output logic                           grant_last,
  output logic [MASTER_NUM-1:0]          starve_flag
);

  localparam int N  = MASTER_NUM;
  localparam int PW = $clog2(N);
  localparam int CW = WEIGHT_BIT + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  localparam logic [WW-1:0]     WAIT_MAX  = WW'(STARVE_LIMIT);
  localparam logic [WW-1:0]     WAIT_ONE  = WW'(1);
  localparam logic [CW-1:0]     CRED_ONE  = CW'(1);
  localparam logic [PW-1:0]     PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]     LAST_IDX  = PW'(N - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] INCR_LAST = BEAT_W'(MAX_INCR_BEATS - 1);
  localparam logic [N-1:0]      REQ_ONE   = N'(1);

  arb_state_t        state_q, state_d;
  logic [N-1:0]      hgrant_q, hgrant_d;
  logic [PW-1:0]     hmaster_q, hmaster_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0] beat_limit_q, beat_limit_d;
  logic [CW-1:0]     credit_q [N];
  logic [CW-1:0]     credit_d [N];
  logic [WW-1:0]     wait_cnt_q [N];
  logic [WW-1:0]     wait_cnt_d [N];

  logic [N-1:0]  starve, starve_req, cred_req;
  logic [N-1:0]  pick_elig, pick_oh, force_oh, win_oh;
  logic          pick_valid, forced, reload;
  logic          owner_req, is_incr, last_beat, arb_en;
  logic [PW-1:0] win_idx;
  logic [CW-1:0] win_credit;
  hburst_t       win_burst;

  always_comb begin
    starve   = '0;
    cred_req = '0;
    for (int i = 0; i < N; i++) begin
      starve[i]   = (wait_cnt_q[i] == WAIT_MAX);
      cred_req[i] = hreq[i] & (credit_q[i] != '0);
    end
    starve_req = starve & hreq;
    forced     = |starve_req;
    reload     = ~forced & ~|cred_req;
    // After a reload every requester holds at least one credit.
    pick_elig  = reload ? hreq : cred_req;
    force_oh   = starve_req & (~starve_req + REQ_ONE);
    win_oh     = forced ? force_oh : pick_oh;
  end

  ahb_rr_pick #(
    .N (N)
  ) u_pick (
    .eligible (pick_elig),
    .rr_ptr   (rr_ptr_q),
    .winner   (pick_oh),
    .valid    (pick_valid)
  );

  always_comb begin
    win_idx   = '0;
    win_burst = HB_SINGLE;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        win_idx   = PW'(i);
        win_burst = hburst_t'(hburst[i*HBURST_W +: HBURST_W]);
      end
    end
  end

  always_comb begin
    owner_req = |(hreq & hgrant_q);
    is_incr   = (beat_limit_q == '0);
    if (is_incr) begin
      last_beat = ~owner_req | (beat_cnt_q == INCR_LAST);
    end else begin
      last_beat = (beat_cnt_q == beat_limit_q - BEAT_ONE);
    end
    grant_last = (state_q == ARB_BUSY) & last_beat;
    arb_en = hready & (forced | pick_valid)
           & ((state_q == ARB_IDLE) | grant_last);
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    win_credit = '0;
    for (int i = 0; i < N; i++) begin
      credit_d[i] = credit_q[i];
    end
    if (arb_en) begin
      for (int i = 0; i < N; i++) begin
        if (reload) begin
          credit_d[i] = {1'b0, weight_cfg[i*WEIGHT_BIT +: WEIGHT_BIT]}
                      + CRED_ONE;
        end
        if (win_oh[i]) begin
          if (credit_d[i] != '0) begin
            credit_d[i] = credit_d[i] - CRED_ONE;
          end
          win_credit = credit_d[i];
        end
      end
      // Stay on the winner while it has credit left.
      if (win_credit != '0) begin
        rr_ptr_d = win_idx;
      end else if (win_idx == LAST_IDX) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_idx + PTR_ONE;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (~hreq[i] | hgrant_q[i]) begin
        wait_cnt_d[i] = '0;
      end else if (!starve[i]) begin
        wait_cnt_d[i] = wait_cnt_q[i] + WAIT_ONE;
      end else begin
        wait_cnt_d[i] = wait_cnt_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hgrant_d     = hgrant_q;
    hmaster_d    = hmaster_q;
    beat_cnt_d   = beat_cnt_q;
    beat_limit_d = beat_limit_q;
    case (state_q)
      ARB_IDLE: state_d = ARB_IDLE;
      ARB_BUSY: begin
        if (hready) begin
          if (!grant_last) begin
            beat_cnt_d = beat_cnt_q + BEAT_ONE;
          end else begin
            state_d    = ARB_IDLE;
            hgrant_d   = '0;
            hmaster_d  = '0;
            beat_cnt_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (arb_en) begin
      state_d      = ARB_BUSY;
      hgrant_d     = win_oh;
      hmaster_d    = win_idx;
      beat_cnt_d   = '0;
      beat_limit_d = burst_beats(win_burst);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ARB_IDLE;
      hgrant_q     <= '0;
      hmaster_q    <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      beat_limit_q <= '0;
      for (int i = 0; i < N; i++) begin
        credit_q[i]   <= '0;
        wait_cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_limit_q <= beat_limit_d;
      for (int i = 0; i < N; i++) begin
        credit_q[i]   <= credit_d[i];
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign hgrant      = hgrant_q;
  assign hmaster     = hmaster_q;
  assign hsel        = |hgrant_q;
  assign starve_flag = starve;

endmodule

// File: tb/tb_ahb_wrr_burst_arbiter.sv
// Bench for ahb_wrr_burst_arbiter: per-cycle behavioural model
// plus directed scenarios with literal expectations.
module tb_ahb_wrr_burst_arbiter;

  localparam int NM   = 4;
  localparam int LIM  = 8;
  localparam int MAXB = 16;

  logic        hclk;
  logic        hreset;
  logic [3:0]  hreq;
  logic [11:0] hburst;
  logic        hready;
  logic [11:0] weight_cfg;
  logic [3:0]  hgrant;
  logic [1:0]  hmaster;
  logic        hsel;
  logic        grant_last;
  logic [3:0]  starve_flag;

  int tests_run;
  int tests_failed;

  ahb_wrr_burst_arbiter #(
    .MASTER_NUM     (NM),
    .WEIGHT_BIT     (3),
    .STARVE_LIMIT   (LIM),
    .MAX_INCR_BEATS (MAXB)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hreq        (hreq),
    .hburst      (hburst),
    .hready      (hready),
    .weight_cfg  (weight_cfg),
    .hgrant      (hgrant),
    .hmaster     (hmaster),
    .hsel        (hsel),
    .grant_last  (grant_last),
    .starve_flag (starve_flag)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Model: who owns the bus, beats done, burst length (0 = INCR),
  // per-master credits and wait cycles, rotating start point.
  bit m_valid;
  int m_busy, m_owner, m_done, m_len, ptr;
  int cred[NM];
  int wt[NM];

  function automatic int beats_of(int hb);
    case (hb)
      0:       return 1;
      1:       return 0;
      2, 3:    return 4;
      4, 5:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int wcfg(int i);
    return int'(weight_cfg[i*3 +: 3]);
  endfunction

  function automatic bit model_last();
    if (m_busy == 0) return 1'b0;
    if (m_len == 0) return (!hreq[m_owner]) || (m_done == MAXB - 1);
    return m_done == m_len - 1;
  endfunction

  task automatic model_step();
    int old_wt[NM];
    int w;
    bit fin, arb, any;
    if (hreset) begin
      m_busy = 0; m_owner = 0; m_done = 0; m_len = 0; ptr = 0;
      for (int i = 0; i < NM; i++) begin
        cred[i] = 0;
        wt[i]   = 0;
      end
      m_valid = 1'b1;
      return;
    end
    fin = model_last();
    arb = hready && (hreq != 4'b0) && (m_busy == 0 || fin);
    for (int i = 0; i < NM; i++) old_wt[i] = wt[i];
    for (int i = 0; i < NM; i++) begin
      if (!hreq[i] || (m_busy != 0 && m_owner == i)) wt[i] = 0;
      else if (wt[i] < LIM) wt[i] = wt[i] + 1;
    end
    if (m_busy != 0 && hready) begin
      if (!fin) m_done = m_done + 1;
      else if (hreq == 4'b0) begin
        m_busy = 0;
        m_owner = 0;
      end
    end
    if (arb) begin
      w = -1;
      for (int i = 0; i < NM; i++)
        if (w < 0 && old_wt[i] == LIM && hreq[i]) w = i;
      if (w < 0) begin
        any = 1'b0;
        for (int i = 0; i < NM; i++)
          if (hreq[i] && cred[i] > 0) any = 1'b1;
        if (!any)
          for (int i = 0; i < NM; i++) cred[i] = wcfg(i) + 1;
        for (int k = 0; k < NM; k++) begin
          int j;
          j = (ptr + k) % NM;
          if (w < 0 && hreq[j] && cred[j] > 0) w = j;
        end
      end
      if (cred[w] > 0) cred[w] = cred[w] - 1;
      ptr = (cred[w] == 0) ? (w + 1) % NM : w;
      m_busy = 1; m_owner = w; m_done = 0;
      m_len = beats_of(int'(hburst[w*3 +: 3]));
    end
  endtask

  task automatic compare();
    logic [3:0] eg, es;
    if (!m_valid) return;
    eg = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
    for (int i = 0; i < NM; i++) es[i] = (wt[i] == LIM);
    chk("m_hgrant", hgrant, eg);
    chk("m_hmaster", hmaster, (m_busy != 0) ? m_owner : 0);
    chk("m_hsel", hsel, m_busy != 0);
    chk("m_grant_last", grant_last, model_last());
    chk("m_starve", starve_flag, es);
  endtask

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge hclk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge hclk);
      compare();
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    hreq   = 4'b0000;
    tick();
    tick();
    hreset = 1'b0;
  endtask

  int exp2[14] = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 1, 2, 3, 3, 3};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    hreset       = 1'b1;
    hreq         = 4'b1111;
    hburst       = '0;
    hready       = 1'b1;
    weight_cfg   = '0;

    // 1: reset holds grant off, first grant one cycle after release
    @(negedge hclk);
    chk("t1_rst_hgrant", hgrant, 4'b0000);
    chk("t1_rst_hsel", hsel, 1'b0);
    tick();
    hreset = 1'b0;
    @(negedge hclk);
    chk("t1_latency", hgrant, 4'b0000);
    @(negedge hclk);
    chk("t1_first", hgrant, 4'b0001);
    chk("t1_hsel", hsel, 1'b1);
    tick();
    hreq = 4'b0000;
    tick();

    // 2: weights m0=0 m1=1 m2=0 m3=2, all SINGLE
    weight_cfg = {3'd2, 3'd0, 3'd1, 3'd0};
    hburst     = '0;
    do_reset();
    hreq = 4'b1111;
    tick();
    for (int j = 0; j < 14; j++) begin
      @(negedge hclk);
      chk("t2_order", hmaster, exp2[j]);
    end
    tick();
    hreq = 4'b0000;
    tick();

    // 3: m2 INCR8 with two wait states
    weight_cfg = '0;
    hburst     = {3'd0, 3'd5, 3'd0, 3'd0};
    do_reset();
    hreq = 4'b0100;
    tick();
    hreq = 4'b0110;
    for (int c = 1; c <= 10; c++) begin
      hready = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      @(negedge hclk);
      chk("t3_hold", hgrant, 4'b0100);
      chk("t3_last", grant_last, c == 10);
      if (c == 10) chk("t3_starve", starve_flag, 4'b0010);
      tick();
    end
    hready = 1'b1;
    @(negedge hclk);
    chk("t3_next", hgrant, 4'b0010);
    tick();
    hreq = 4'b0000;
    tick();
    tick();

    // 4: INCR ends on request drop, or at the beat cap
    hburst = {3'd0, 3'd0, 3'd0, 3'd1};
    do_reset();
    hreq = 4'b0001;
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) hreq = 4'b0000;
      @(negedge hclk);
      chk("t4_hold", hgrant, 4'b0001);
      chk("t4_last", grant_last, c == 5);
      tick();
    end
    @(negedge hclk);
    chk("t4_idle", hgrant, 4'b0000);
    tick();
    hreq = 4'b0001;
    tick();
    for (int c = 1; c <= 16; c++) begin
      @(negedge hclk);
      chk("t4_cap_hold", hgrant, 4'b0001);
      chk("t4_cap_last", grant_last, c == 16);
      tick();
    end
    @(negedge hclk);
    chk("t4_b2b", hgrant, 4'b0001);
    chk("t4_b2b_last", grant_last, 1'b0);
    tick();
    hreq = 4'b0000;
    tick();
    tick();

    // 5: starving m3 against heavy m0 INCR16 bursts
    weight_cfg = {3'd0, 3'd0, 3'd0, 3'd7};
    hburst     = {3'd0, 3'd0, 3'd0, 3'd7};
    do_reset();
    hreq = 4'b1001;
    tick();
    for (int c = 1; c <= 16; c++) begin
      @(negedge hclk);
      chk("t5_hold", hgrant, 4'b0001);
      if (c == 7) chk("t5_not_yet", starve_flag[3], 1'b0);
      if (c == 8) chk("t5_flag", starve_flag[3], 1'b1);
      if (c == 16) chk("t5_last", grant_last, 1'b1);
      tick();
    end
    @(negedge hclk);
    chk("t5_forced", hgrant, 4'b1000);
    chk("t5_hmaster", hmaster, 2'd3);
    tick();
    hreq = 4'b0000;
    tick();
    tick();

    // 6: reset in the middle of a WRAP16 burst
    weight_cfg = '0;
    hburst     = {3'd0, 3'd0, 3'd6, 3'd0};
    do_reset();
    hreq = 4'b0010;
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) hreset = 1'b1;
      @(negedge hclk);
      chk("t6_hold", hgrant, 4'b0010);
      tick();
    end
    hreset = 1'b0;
    @(negedge hclk);
    chk("t6_drop", hgrant, 4'b0000);
    chk("t6_hsel", hsel, 1'b0);
    chk("t6_hmaster", hmaster, 2'd0);
    @(negedge hclk);
    chk("t6_regrant", hgrant, 4'b0010);
    tick();
    hreq = 4'b0000;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
